// File: rtl/fwd_pkg.sv
// Shared types and defaults for the operand-forwarding / scoreboard block.
package fwd_pkg;

    typedef enum logic [2:0] {
        FWD_RF      = 3'd0,
        FWD_EX      = 3'd1,
        FWD_MM_ALU  = 3'd2,
        FWD_MM_LOAD = 3'd3,
        FWD_WB      = 3'd4,
        FWD_LU      = 3'd5
    } fwd_src_e;

    localparam int unsigned FWD_DATA_WIDTH = 32;
    localparam int unsigned FWD_REG_NUM    = 32;

endpackage

// File: rtl/fwd_port_sel.sv
// One source-read port: newest-producer priority match and operand mux.
module fwd_port_sel
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FWD_DATA_WIDTH,
    parameter int unsigned RW         = 5
) (
    input  logic [RW-1:0]         rs_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    input  logic                  ex_wr_en,
    input  logic                  ex_is_load,
    input  logic [RW-1:0]         ex_rd,
    input  logic [DATA_WIDTH-1:0] ex_data,
    input  logic                  mm_wr_en,
    input  logic                  mm_is_load,
    input  logic [RW-1:0]         mm_rd,
    input  logic [DATA_WIDTH-1:0] mm_alu,
    input  logic [DATA_WIDTH-1:0] mm_mem,
    input  logic                  wb_wr_en,
    input  logic [RW-1:0]         wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  lu_done,
    input  logic [RW-1:0]         lu_done_rd,
    input  logic [DATA_WIDTH-1:0] lu_data,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output fwd_src_e              fwd_src,
    output logic                  load_use
);

    always_comb begin
        fwd_data = '0;
        fwd_src  = FWD_RF;
        load_use = 1'b0;
        // x0 is hardwired to zero regardless of any producer or rf_data.
        if (rs_addr != '0) begin
            if (ex_wr_en && (ex_rd == rs_addr)) begin
                // A load in EX has no data yet; the consumer is stalled.
                fwd_data = ex_data;
                fwd_src  = FWD_EX;
                load_use = ex_is_load;
            end else if (mm_wr_en && (mm_rd == rs_addr)) begin
                if (mm_is_load) begin
                    fwd_data = mm_mem;
                    fwd_src  = FWD_MM_LOAD;
                end else begin
                    fwd_data = mm_alu;
                    fwd_src  = FWD_MM_ALU;
                end
            end else if (wb_wr_en && (wb_rd == rs_addr)) begin
                fwd_data = wb_data;
                fwd_src  = FWD_WB;
            end else if (lu_done && (lu_done_rd == rs_addr)) begin
                fwd_data = lu_data;
                fwd_src  = FWD_LU;
            end else begin
                fwd_data = rf_data;
                fwd_src  = FWD_RF;
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Decode-stage forwarding unit with long-latency scoreboard, stall generation
// and a saturating stall-cycle counter.
module fwd_scoreboard
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FWD_DATA_WIDTH,
    parameter int unsigned REG_NUM    = FWD_REG_NUM,
    parameter int unsigned NUM_RS     = 2,
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned RW         = $clog2(REG_NUM)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_RS-1:0]                    rs_used,
    input  logic [NUM_RS-1:0][RW-1:0]            rs_addr,
    input  logic [NUM_RS-1:0][DATA_WIDTH-1:0]    rf_data,
    input  logic                                 ex_wr_en,
    input  logic                                 ex_is_load,
    input  logic [RW-1:0]                        ex_rd,
    input  logic [DATA_WIDTH-1:0]                ex_data,
    input  logic                                 mm_wr_en,
    input  logic                                 mm_is_load,
    input  logic [RW-1:0]                        mm_rd,
    input  logic [DATA_WIDTH-1:0]                mm_alu,
    input  logic [DATA_WIDTH-1:0]                mm_mem,
    input  logic                                 wb_wr_en,
    input  logic [RW-1:0]                        wb_rd,
    input  logic [DATA_WIDTH-1:0]                wb_data,
    input  logic                                 lu_issue,
    input  logic [RW-1:0]                        lu_issue_rd,
    input  logic                                 lu_done,
    input  logic [RW-1:0]                        lu_done_rd,
    input  logic [DATA_WIDTH-1:0]                lu_data,
    input  logic                                 flush,
    output logic [NUM_RS-1:0][DATA_WIDTH-1:0]    fwd_data,
    output logic [NUM_RS-1:0][2:0]               fwd_src,
    output logic                                 stall,
    output logic [REG_NUM-1:0]                   sb_busy,
    output logic [CNT_WIDTH-1:0]                 stall_count
);

    logic [REG_NUM-1:0]   sb_q, sb_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [NUM_RS-1:0]    load_use;
    logic [NUM_RS-1:0]    sb_hit;
    logic                 waw_hit;

    for (genvar gi = 0; gi < NUM_RS; gi++) begin : g_port
        fwd_src_e port_src;

        fwd_port_sel #(
            .DATA_WIDTH(DATA_WIDTH),
            .RW        (RW)
        ) u_port_sel (
            .rs_addr   (rs_addr[gi]),
            .rf_data   (rf_data[gi]),
            .ex_wr_en  (ex_wr_en),
            .ex_is_load(ex_is_load),
            .ex_rd     (ex_rd),
            .ex_data   (ex_data),
            .mm_wr_en  (mm_wr_en),
            .mm_is_load(mm_is_load),
            .mm_rd     (mm_rd),
            .mm_alu    (mm_alu),
            .mm_mem    (mm_mem),
            .wb_wr_en  (wb_wr_en),
            .wb_rd     (wb_rd),
            .wb_data   (wb_data),
            .lu_done   (lu_done),
            .lu_done_rd(lu_done_rd),
            .lu_data   (lu_data),
            .fwd_data  (fwd_data[gi]),
            .fwd_src   (port_src),
            .load_use  (load_use[gi])
        );

        assign fwd_src[gi] = port_src;
    end

    // A result completing this cycle is forwarded, so it never stalls a reader
    // nor blocks a re-issue to the same register.
    always_comb begin
        sb_hit = '0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            sb_hit[i] = rs_used[i] && sb_q[rs_addr[i]] &&
                        !(lu_done && (lu_done_rd == rs_addr[i]));
        end
        waw_hit = lu_issue && sb_q[lu_issue_rd] && !(lu_done && (lu_done_rd == lu_issue_rd));
    end

    assign stall = (|(load_use & rs_used)) | (!rst && ((|sb_hit) || waw_hit));

    always_comb begin
        sb_d = sb_q;
        if (flush) begin
            sb_d = '0;
        end else begin
            if (lu_done) begin
                sb_d[lu_done_rd] = 1'b0;
            end
            if (lu_issue && !stall && (lu_issue_rd != '0)) begin
                sb_d[lu_issue_rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q <= sb_d;
            if (stall && (cnt_q != {CNT_WIDTH{1'b1}})) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign sb_busy     = sb_q;
    assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed self-checking bench for fwd_scoreboard (4-bit stall counter).
module tb_fwd_scoreboard;
    import fwd_pkg::*;

    logic             clk;
    logic             rst;
    logic [1:0]       rs_used;
    logic [1:0][4:0]  rs_addr;
    logic [1:0][31:0] rf_data;
    logic             ex_wr_en, ex_is_load;
    logic [4:0]       ex_rd;
    logic [31:0]      ex_data;
    logic             mm_wr_en, mm_is_load;
    logic [4:0]       mm_rd;
    logic [31:0]      mm_alu, mm_mem;
    logic             wb_wr_en;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             lu_issue;
    logic [4:0]       lu_issue_rd;
    logic             lu_done;
    logic [4:0]       lu_done_rd;
    logic [31:0]      lu_data;
    logic             flush;
    logic [1:0][31:0] fwd_data;
    logic [1:0][2:0]  fwd_src;
    logic             stall;
    logic [31:0]      sb_busy;
    logic [3:0]       stall_count;

    int errors = 0;
    int checks = 0;

    fwd_scoreboard #(
        .DATA_WIDTH(32),
        .REG_NUM   (32),
        .NUM_RS    (2),
        .CNT_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs_used    (rs_used),
        .rs_addr    (rs_addr),
        .rf_data    (rf_data),
        .ex_wr_en   (ex_wr_en),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_data    (ex_data),
        .mm_wr_en   (mm_wr_en),
        .mm_is_load (mm_is_load),
        .mm_rd      (mm_rd),
        .mm_alu     (mm_alu),
        .mm_mem     (mm_mem),
        .wb_wr_en   (wb_wr_en),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .lu_issue   (lu_issue),
        .lu_issue_rd(lu_issue_rd),
        .lu_done    (lu_done),
        .lu_done_rd (lu_done_rd),
        .lu_data    (lu_data),
        .flush      (flush),
        .fwd_data   (fwd_data),
        .fwd_src    (fwd_src),
        .stall      (stall),
        .sb_busy    (sb_busy),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs_used = '0; rs_addr = '0; rf_data = '0;
        ex_wr_en = 0; ex_is_load = 0; ex_rd = '0; ex_data = '0;
        mm_wr_en = 0; mm_is_load = 0; mm_rd = '0; mm_alu = '0; mm_mem = '0;
        wb_wr_en = 0; wb_rd = '0; wb_data = '0;
        lu_issue = 0; lu_issue_rd = '0; lu_done = 0; lu_done_rd = '0; lu_data = '0;
        flush = 0;
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        next_cycle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #12;
        check_eq("reset_sb_busy", 64'(sb_busy), 64'h0);
        check_eq("reset_count", 64'(stall_count), 64'h0);
        check_eq("reset_stall", 64'(stall), 64'h0);
        @(negedge clk) rst = 1'b0;
        next_cycle();

        // EX beats MM for the same register.
        ex_wr_en = 1; ex_rd = 5; ex_data = 32'h11;
        mm_wr_en = 1; mm_rd = 5; mm_alu = 32'h22;
        rs_used = 2'b01; rs_addr[0] = 5;
        #1;
        check_eq("ex_data", 64'(fwd_data[0]), 64'h11);
        check_eq("ex_src", 64'(fwd_src[0]), 64'(FWD_EX));
        check_eq("ex_stall", 64'(stall), 64'h0);
        ex_wr_en = 0;
        #1;
        check_eq("mm_alu_data", 64'(fwd_data[0]), 64'h22);
        check_eq("mm_alu_src", 64'(fwd_src[0]), 64'(FWD_MM_ALU));
        mm_wr_en = 0; wb_wr_en = 1; wb_rd = 5; wb_data = 32'h33;
        #1;
        check_eq("wb_data", 64'(fwd_data[0]), 64'h33);
        check_eq("wb_src", 64'(fwd_src[0]), 64'(FWD_WB));
        wb_wr_en = 0; rf_data[0] = 32'h44;
        #1;
        check_eq("rf_data", 64'(fwd_data[0]), 64'h44);
        check_eq("rf_src", 64'(fwd_src[0]), 64'(FWD_RF));

        // x0 reads zero even with every producer targeting it.
        idle();
        rs_used = 2'b10; rs_addr[1] = 0; rf_data[1] = 32'hFF;
        ex_wr_en = 1; ex_data = 32'hFF; mm_wr_en = 1; mm_alu = 32'hFF;
        wb_wr_en = 1; wb_data = 32'hFF; lu_done = 1; lu_data = 32'hFF;
        #1;
        check_eq("x0_data", 64'(fwd_data[1]), 64'h0);
        check_eq("x0_src", 64'(fwd_src[1]), 64'(FWD_RF));
        next_cycle();

        // Load-use: stall while the load is in EX, forward from MM next cycle.
        idle();
        ex_wr_en = 1; ex_is_load = 1; ex_rd = 7;
        rs_used = 2'b01; rs_addr[0] = 7;
        #1;
        check_eq("loaduse_stall", 64'(stall), 64'h1);
        next_cycle();
        idle();
        rs_used = 2'b01; rs_addr[0] = 7;
        mm_wr_en = 1; mm_is_load = 1; mm_rd = 7; mm_mem = 32'hABCD; mm_alu = 32'h5555;
        #1;
        check_eq("mm_load_data", 64'(fwd_data[0]), 64'hABCD);
        check_eq("mm_load_src", 64'(fwd_src[0]), 64'(FWD_MM_LOAD));
        check_eq("mm_load_stall", 64'(stall), 64'h0);
        check_eq("loaduse_count", 64'(stall_count), 64'h1);
        idle();
        pulse_reset();
        check_eq("pulse_reset_count", 64'(stall_count), 64'h0);

        // Long-latency issue of x9, three stalled reads, then completion.
        lu_issue = 1; lu_issue_rd = 9;
        next_cycle();
        idle();
        check_eq("issue9_busy", 64'(sb_busy), 64'h200);
        rs_used = 2'b01; rs_addr[0] = 9;
        #1;
        check_eq("sb_stall", 64'(stall), 64'h1);
        next_cycle();
        next_cycle();
        next_cycle();
        check_eq("sb_count3", 64'(stall_count), 64'h3);
        lu_done = 1; lu_done_rd = 9; lu_data = 32'h99;
        #1;
        check_eq("lu_data", 64'(fwd_data[0]), 64'h99);
        check_eq("lu_src", 64'(fwd_src[0]), 64'(FWD_LU));
        check_eq("lu_stall", 64'(stall), 64'h0);
        next_cycle();
        idle();
        check_eq("done9_busy", 64'(sb_busy), 64'h0);
        check_eq("done9_count", 64'(stall_count), 64'h3);

        // Two issues then flush with a simultaneous issue.
        lu_issue = 1; lu_issue_rd = 3;
        next_cycle();
        lu_issue_rd = 4;
        next_cycle();
        check_eq("issue34_busy", 64'(sb_busy), 64'h18);
        lu_issue_rd = 6; flush = 1;
        next_cycle();
        idle();
        check_eq("flush_busy", 64'(sb_busy), 64'h0);

        // WAW stall, then issue+done to the same register keeps it busy.
        lu_issue = 1; lu_issue_rd = 10;
        next_cycle();
        #1;
        check_eq("waw_stall", 64'(stall), 64'h1);
        next_cycle();
        check_eq("waw_count", 64'(stall_count), 64'h4);
        lu_done = 1; lu_done_rd = 10;
        #1;
        check_eq("reissue_stall", 64'(stall), 64'h0);
        next_cycle();
        idle();
        check_eq("reissue_busy", 64'(sb_busy), 64'h400);
        // Issue to x0 never marks it busy.
        flush = 1;
        next_cycle();
        idle();
        lu_issue = 1; lu_issue_rd = 0;
        next_cycle();
        idle();
        check_eq("x0_issue_busy", 64'(sb_busy), 64'h0);

        // Saturation: from zero, 14 stalled cycles give 14, then pins at 15.
        pulse_reset();
        lu_issue = 1; lu_issue_rd = 11;
        next_cycle();
        idle();
        ex_wr_en = 1; ex_is_load = 1; ex_rd = 7;
        rs_used = 2'b01; rs_addr[0] = 7;
        repeat (14) next_cycle();
        check_eq("sat_count14", 64'(stall_count), 64'hE);
        next_cycle();
        check_eq("sat_count15", 64'(stall_count), 64'hF);
        repeat (2) next_cycle();
        check_eq("sat_hold15", 64'(stall_count), 64'hF);
        check_eq("sat_busy11", 64'(sb_busy), 64'h800);

        // Asynchronous reset mid-cycle.
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_count", 64'(stall_count), 64'h0);
        check_eq("async_rst_busy", 64'(sb_busy), 64'h0);
        check_eq("rst_loaduse_stall", 64'(stall), 64'h1);
        idle();
        #1;
        check_eq("rst_idle_stall", 64'(stall), 64'h0);
        @(negedge clk) rst = 1'b0;
        next_cycle();
        // Late completion after reset is a no-op.
        lu_done = 1; lu_done_rd = 11; rs_used = 2'b01; rs_addr[0] = 11;
        #1;
        check_eq("late_done_stall", 64'(stall), 64'h0);
        next_cycle();
        idle();
        check_eq("late_done_busy", 64'(sb_busy), 64'h0);
        check_eq("late_done_count", 64'(stall_count), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
